// File: rtl/decoder_n_scan.sv
// ---------------------------------------------------------------------------
// decoder_n_scan
// Registered SEL_W-to-2**SEL_W one-hot (or one-cold) decoder with two modes:
//   direct : cur_sel captures sel_in on sel_vld, y decodes cur_sel
//   scan   : cur_sel steps cyclically, each index held DIV_MAX+1 clocks
//
// Ports
//   sys_clk    in   1      rising-edge clock
//   sys_rst_n  in   1      asynchronous active-low reset
//   en         in   1      output enable; low forces y inactive and freezes scan
//   mode       in   1      0 = direct decode, 1 = scan
//   sel_in     in   SEL_W  direct-mode select value
//   sel_vld    in   1      capture strobe for sel_in (direct mode only)
//   skip_mask  in   OUT_W  indices to skip while scanning (DECODER_SKIP_EN only)
//   y          out  OUT_W  registered decode output
//   cur_sel    out  SEL_W  registered current index
//   wrap       out  1      one-clock pulse when the scan index wraps
//
// Optional feature macro: DECODER_SKIP_EN (adds skip_mask).
// ---------------------------------------------------------------------------
module decoder_n_scan #(
    parameter int unsigned SEL_W      = 3,
    parameter int unsigned DIV_MAX    = 49999,
    parameter bit          ACTIVE_LOW = 1'b0
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
    input  logic                    en,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel_in,
    input  logic                    sel_vld,
`ifdef DECODER_SKIP_EN
    input  logic [(2**SEL_W)-1:0]   skip_mask,
`endif
    output logic [(2**SEL_W)-1:0]   y,
    output logic [SEL_W-1:0]        cur_sel,
    output logic                    wrap
);

    localparam int unsigned OUT_W = 2**SEL_W;
    localparam int unsigned CNT_W = (DIV_MAX < 1) ? 1 : $clog2(DIV_MAX + 1);

    localparam logic [OUT_W-1:0] Y_IDLE   = {OUT_W{ACTIVE_LOW}};
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DIV_MAX);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [SEL_W-1:0] sel_nxt;
    logic             wrap_nxt;
    logic [OUT_W-1:0] y_nxt;
    logic             mode_d;

    logic [SEL_W-1:0] step_sel;
    logic             step_wrap;
    logic             scan_stall;

`ifdef DECODER_SKIP_EN
    logic [SEL_W-1:0] cand;
    logic             found;

    // Next unmasked index after cur_sel, searched cyclically; the last
    // candidate (offset OUT_W) is cur_sel itself.
    always_comb begin
        step_sel  = cur_sel;
        step_wrap = 1'b0;
        cand      = cur_sel;
        found     = 1'b0;
        for (int unsigned i = 1; i <= OUT_W; i++) begin
            cand = cur_sel + SEL_W'(i);
            if (!found && !skip_mask[cand]) begin
                step_sel = cand;
                found    = 1'b1;
            end
        end
        step_wrap  = found && (step_sel <= cur_sel);
        scan_stall = &skip_mask;
    end
`else
    // Plain cyclic step; natural modulo-2**SEL_W wrap.
    always_comb begin
        step_sel   = cur_sel + SEL_W'(1);
        step_wrap  = &cur_sel;
        scan_stall = 1'b0;
    end
`endif

    // Next-state for index, dwell counter, wrap pulse and output.
    always_comb begin
        cnt_nxt  = cnt;
        sel_nxt  = cur_sel;
        wrap_nxt = 1'b0;
        y_nxt    = Y_IDLE;

        if (!en) begin
            cnt_nxt = '0;
        end else if (!mode) begin
            cnt_nxt = '0;
            if (sel_vld) begin
                sel_nxt = sel_in;
            end
        end else if (!mode_d || scan_stall) begin
            // entering scan restarts the dwell so the first index gets a full period
            cnt_nxt = '0;
        end else if (cnt == CNT_TERM) begin
            cnt_nxt  = '0;
            sel_nxt  = step_sel;
            wrap_nxt = step_wrap;
        end else begin
            cnt_nxt = cnt + CNT_W'(1);
        end

        if (en && !(mode && scan_stall)) begin
            y_nxt = Y_IDLE ^ (OUT_W'(1) << cur_sel);
        end
    end

    // State and output registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt     <= '0;
            cur_sel <= '0;
            wrap    <= 1'b0;
            y       <= Y_IDLE;
            mode_d  <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            cur_sel <= sel_nxt;
            wrap    <= wrap_nxt;
            y       <= y_nxt;
            mode_d  <= mode;
        end
    end

endmodule
